// File: rtl/cache_tag_ctrl.sv
// Tag-lookup controller for a 16-set direct-mapped cache: single-port tag SRAM,
// valid/dirty kept in flops, back-to-back lookups, fills take priority over requests.
module cache_tag_ctrl #(
    parameter int unsigned TAG_W = 23,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned OFF_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_dirty,
    output logic [TAG_W-1:0] resp_victim_tag,
    output logic [IDX_W-1:0] resp_set,
    input  logic             fill_valid,
    output logic             fill_ready,
    input  logic [31:0]      fill_addr,
    input  logic             fill_dirty,
    output logic             sram_csb0,
    output logic             sram_web0,
    output logic [IDX_W-1:0] sram_addr0,
    output logic [TAG_W-1:0] sram_din0,
    input  logic [TAG_W-1:0] sram_dout0
);
    localparam int unsigned SETS = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t            state;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [IDX_W-1:0]  addr_q;
    logic [TAG_W-1:0]  din_q;

    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  fill_idx;
    logic              fill_acc;
    logic              req_acc;
    logic              in_lookup;
    logic              hit;
    logic              unused_off;

    assign req_tag    = req_addr[OFF_W+IDX_W +: TAG_W];
    assign req_idx    = req_addr[OFF_W +: IDX_W];
    assign fill_tag   = fill_addr[OFF_W+IDX_W +: TAG_W];
    assign fill_idx   = fill_addr[OFF_W +: IDX_W];
    assign unused_off = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

    // Handshakes, lookup result and SRAM port; the SRAM must see the access in the accept cycle.
    always_comb begin
        fill_ready      = 1'b0;
        req_ready       = 1'b0;
        fill_acc        = 1'b0;
        req_acc         = 1'b0;
        in_lookup       = 1'b0;
        hit             = 1'b0;
        resp_valid      = 1'b0;
        resp_hit        = 1'b0;
        resp_dirty      = 1'b0;
        resp_victim_tag = '0;
        resp_set        = '0;
        sram_csb0       = 1'b1;
        sram_web0       = 1'b1;
        sram_addr0      = addr_q;
        sram_din0       = din_q;

        fill_ready = !rst && (state != FILL);
        req_ready  = fill_ready && !fill_valid;
        fill_acc   = fill_valid && fill_ready;
        req_acc    = req_valid && req_ready;
        in_lookup  = !rst && (state == LOOKUP);
        hit        = in_lookup && valid_q[idx_q] && (sram_dout0 == tag_q);

        if (in_lookup) begin
            resp_valid      = 1'b1;
            resp_hit        = hit;
            resp_dirty      = valid_q[idx_q] && dirty_q[idx_q] && !hit;
            resp_victim_tag = sram_dout0;
            resp_set        = idx_q;
        end

        if (fill_acc) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = fill_idx;
            sram_din0  = fill_tag;
        end else if (req_acc) begin
            sram_csb0  = 1'b0;
            sram_addr0 = req_idx;
        end
    end

    // Address/data hold registers so an idle SRAM port keeps its last values.
    always_ff @(posedge clk) begin
        addr_q <= sram_addr0;
        din_q  <= sram_din0;
    end

    // State, request latch and valid/dirty arrays; a fill is applied after the write-hit so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            if (hit && write_q) begin
                dirty_q[idx_q] <= 1'b1;
            end
            if (fill_acc) begin
                valid_q[fill_idx] <= 1'b1;
                dirty_q[fill_idx] <= fill_dirty;
                state             <= FILL;
            end else if (req_acc) begin
                tag_q   <= req_tag;
                idx_q   <= req_idx;
                write_q <= req_write;
                state   <= LOOKUP;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: directed scenarios plus random traffic against a set-level cache model.
module tb_cache_tag_ctrl;
    localparam int unsigned TAG_W = 23;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned OFF_W = 5;
    localparam int unsigned SETS  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic             req_write;
    logic             resp_valid;
    logic             resp_hit;
    logic             resp_dirty;
    logic [TAG_W-1:0] resp_victim_tag;
    logic [IDX_W-1:0] resp_set;
    logic             fill_valid;
    logic             fill_ready;
    logic [31:0]      fill_addr;
    logic             fill_dirty;
    logic             sram_csb0;
    logic             sram_web0;
    logic [IDX_W-1:0] sram_addr0;
    logic [TAG_W-1:0] sram_din0;
    logic [TAG_W-1:0] sram_dout0;

    always #5 clk = ~clk;

    cache_tag_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_dirty(resp_dirty),
        .resp_victim_tag(resp_victim_tag), .resp_set(resp_set),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr), .fill_dirty(fill_dirty),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Tag SRAM: unwritten entries return arbitrary seed contents.
    logic [TAG_W-1:0] seed [SETS];
    logic [TAG_W-1:0] mem  [SETS];
    logic [SETS-1:0]  written = '0;
    logic             wr_pend = 1'b0;
    logic [IDX_W-1:0] wr_addr;
    logic [TAG_W-1:0] wr_din;
    logic [TAG_W-1:0] dout_r = '0;
    assign sram_dout0 = dout_r;

    always @(posedge clk) begin
        if (wr_pend) begin
            mem[wr_addr]     <= wr_din;
            written[wr_addr] <= 1'b1;
        end
        wr_pend <= !sram_csb0 && !sram_web0;
        wr_addr <= sram_addr0;
        wr_din  <= sram_din0;
        if (!sram_csb0 && sram_web0)
            dout_r <= written[sram_addr0] ? mem[sram_addr0] : seed[sram_addr0];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference cache state: per-set valid, dirty and stored tag.
    typedef struct {
        logic             hit;
        logic             dirty;
        logic [TAG_W-1:0] victim;
        logic [IDX_W-1:0] set;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic             mv [SETS];
    logic             md [SETS];
    logic [TAG_W-1:0] mt [SETS];
    logic             prev_fill = 1'b0;
    logic             last_f, last_r;
    int               last_f_cyc, last_r_cyc;
    logic             addr_known = 1'b0;
    logic             din_known  = 1'b0;
    logic [IDX_W-1:0] hold_addr;
    logic [TAG_W-1:0] hold_din;

    // One clock cycle: judge handshakes from the model's view of readiness and update the model.
    task automatic cycle();
        logic             f_acc, r_acc;
        logic [IDX_W-1:0] fi, ri;
        logic [TAG_W-1:0] ft, rt;
        exp_t             e;
        @(negedge clk);
        fi = fill_addr[OFF_W +: IDX_W];
        ft = fill_addr[OFF_W+IDX_W +: TAG_W];
        ri = req_addr[OFF_W +: IDX_W];
        rt = req_addr[OFF_W+IDX_W +: TAG_W];
        f_acc = 1'b0;
        r_acc = 1'b0;
        if (rst) begin
            chk("rst_outputs", 32'({req_ready, fill_ready, resp_valid, sram_csb0, sram_web0}), 32'b00011);
            for (int s = 0; s < SETS; s++) begin
                mv[s] = 1'b0;
                md[s] = 1'b0;
            end
            sb.delete();
            prev_fill = 1'b0;
        end else begin
            chk("fill_ready", 32'(fill_ready), 32'(!prev_fill));
            chk("req_ready", 32'(req_ready), 32'(!prev_fill && !fill_valid));
            f_acc = fill_valid && !prev_fill;
            r_acc = req_valid && !prev_fill && !fill_valid;
            if (f_acc) begin
                chk("sram_fill", 32'({sram_csb0, sram_web0, sram_addr0, sram_din0}), 32'({2'b00, fi, ft}));
                mv[fi] = 1'b1;
                md[fi] = fill_dirty;
                mt[fi] = ft;
                hold_addr = fi;
                hold_din  = ft;
                addr_known = 1'b1;
                din_known  = 1'b1;
                last_f_cyc = cyc;
            end else if (r_acc) begin
                chk("sram_read", 32'({sram_csb0, sram_web0, sram_addr0}), 32'({2'b01, ri}));
                e.hit    = mv[ri] && (mt[ri] == rt);
                e.dirty  = mv[ri] && md[ri] && !e.hit;
                e.victim = mt[ri];
                e.set    = ri;
                e.cyc    = cyc + 1;
                sb.push_back(e);
                if (e.hit && req_write) md[ri] = 1'b1;
                hold_addr = ri;
                addr_known = 1'b1;
                last_r_cyc = cyc;
            end else begin
                chk("sram_idle", 32'({sram_csb0, sram_web0}), 32'b11);
                if (addr_known) chk("sram_addr_hold", 32'(sram_addr0), 32'(hold_addr));
                if (din_known)  chk("sram_din_hold", 32'(sram_din0), 32'(hold_din));
            end
            prev_fill = f_acc;
        end
        last_f = f_acc;
        last_r = r_acc;
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops the scoreboard on every resp_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("resp_missing", 32'(0), 32'(e.cyc));
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                chk("resp_dirty", 32'(resp_dirty), 32'(e.dirty));
                chk("resp_victim_tag", 32'(resp_victim_tag), 32'(e.victim));
                chk("resp_set", 32'(resp_set), 32'(e.set));
            end
        end else begin
            chk("resp_idle_zero", 32'({resp_hit, resp_dirty, resp_victim_tag, resp_set}), 32'(0));
        end
    end

    // Hold each asserted valid until the model says it was taken.
    task automatic xfer(input logic rv, input logic [31:0] ra, input logic rw,
                        input logic fv, input logic [31:0] fa, input logic fd);
        req_valid = rv; req_addr = ra; req_write = rw;
        fill_valid = fv; fill_addr = fa; fill_dirty = fd;
        for (int i = 0; i < 8 && (req_valid || fill_valid); i++) begin
            cycle();
            if (last_f) fill_valid = 1'b0;
            if (last_r) req_valid = 1'b0;
        end
        chk("xfer_accept", 32'({req_valid, fill_valid}), 32'(0));
        req_valid = 1'b0;
        fill_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        fill_valid = 1'b0;
        repeat (n) cycle();
    endtask

    function automatic logic [31:0] mk(input int tag, input int set);
        return {TAG_W'(tag), IDX_W'(set), OFF_W'($urandom)};
    endfunction

    int first_acc;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        fill_valid = 1'b0; fill_addr = '0; fill_dirty = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            seed[s] = TAG_W'($urandom);
            mt[s]   = seed[s];
        end
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;

        // Cold miss, fill, read hit, write hit then conflicting miss with writeback.
        xfer(1'b1, 32'h0000_1040, 1'b0, 1'b0, '0, 1'b0);
        idle(2);
        xfer(1'b0, '0, 1'b0, 1'b1, 32'h0000_1040, 1'b0);
        xfer(1'b1, 32'h0000_1040, 1'b0, 1'b0, '0, 1'b0);
        xfer(1'b1, 32'h0000_1040, 1'b1, 1'b0, '0, 1'b0);
        xfer(1'b1, 32'h0000_3040, 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // Simultaneous fill and request: fill first, request two cycles later.
        xfer(1'b1, 32'h0000_2060, 1'b0, 1'b1, 32'h0000_2060, 1'b1);
        chk("fill_priority_gap", 32'(last_r_cyc - last_f_cyc), 32'(2));
        idle(2);

        // Fill every set, then sixteen back-to-back hits.
        for (int s = 0; s < SETS; s++) xfer(1'b0, '0, 1'b0, 1'b1, mk(100 + s, s), 1'(s));
        first_acc = -1;
        for (int s = 0; s < SETS; s++) begin
            xfer(1'b1, mk(100 + s, s), 1'b0, 1'b0, '0, 1'b0);
            if (first_acc < 0) first_acc = last_r_cyc;
        end
        chk("b2b_span", 32'(last_r_cyc - first_acc), 32'(SETS - 1));
        idle(2);

        // Reset during a lookup drops the response and invalidates everything.
        xfer(1'b1, mk(103, 3), 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        xfer(1'b1, mk(105, 5), 1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // Random traffic with a small tag pool to mix hits, conflicts and dirty victims.
        for (int i = 0; i < 1500; i++) begin
            rst        = ($urandom_range(0, 79) == 0);
            req_valid  = 1'($urandom);
            req_write  = 1'($urandom);
            req_addr   = mk(100 + int'($urandom_range(0, 3)), int'($urandom_range(0, SETS - 1)));
            fill_valid = ($urandom_range(0, 3) == 0);
            fill_dirty = 1'($urandom);
            fill_addr  = mk(100 + int'($urandom_range(0, 3)), int'($urandom_range(0, SETS - 1)));
            cycle();
        end
        rst = 1'b0;
        idle(4);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 The block SHALL have these parameters: TAG_W, default 23, tag width; IDX_W, default 4, set-index width (16 sets); OFF_W, default 5, line offset width.
REQ-003 The address split SHALL be tag = addr[31:9], index = addr[8:5], offset = addr[4:0], with the default parameters.
REQ-004 The block SHALL have these request ports: req_valid in 1, lookup request; req_ready out 1, lookup accepted; req_addr in 32, byte address; req_write in 1, store (marks the line dirty on a hit).
REQ-005 The block SHALL have these response ports: resp_valid out 1, one-cycle pulse; resp_hit out 1; resp_dirty out 1, victim needs writeback; resp_victim_tag out TAG_W; resp_set out IDX_W.
REQ-006 The block SHALL have these fill ports: fill_valid in 1, tag install; fill_ready out 1; fill_addr in 32; fill_dirty in 1, initial dirty state.
REQ-007 The block SHALL have these SRAM ports: sram_csb0 out 1, active-low select; sram_web0 out 1, active-low write; sram_addr0 out IDX_W; sram_din0 out TAG_W; sram_dout0 in TAG_W.

Function
REQ-008 The block SHALL assume these tag-SRAM timing rules: the SRAM registers csb/web/addr/din on the clk edge where csb0=0; read data is valid on sram_dout0 during the following cycle; a write commits on the edge after capture.
REQ-009 Valid and dirty state SHALL be held in two 16-entry flop arrays inside this block, because SRAM contents are undefined after reset.
REQ-010 The FSM SHALL have the states IDLE, LOOKUP and FILL.
REQ-011 In IDLE and LOOKUP: fill_ready=1, and req_ready = !fill_valid. In FILL: both ready signals = 0.
REQ-012 Request accept (req_valid && req_ready) SHALL drive, in the same cycle, sram_csb0=0, sram_web0=1 and sram_addr0=index; latch tag, index and write; next state is LOOKUP.
REQ-013 In LOOKUP, resp_valid SHALL be 1 for exactly that cycle.
REQ-014 In LOOKUP, resp_hit SHALL be valid[idx] && (sram_dout0 == latched tag).
REQ-015 In LOOKUP, resp_dirty SHALL be valid[idx] && dirty[idx] && !resp_hit.
REQ-016 In LOOKUP, resp_victim_tag SHALL be sram_dout0 and resp_set SHALL be idx.
REQ-017 A hit with write=1 SHALL set dirty[idx] at the end of the LOOKUP cycle.
REQ-018 A new request accepted during LOOKUP SHALL give back-to-back lookups, one response per cycle; next state stays LOOKUP.
REQ-019 When no request is accepted in LOOKUP, the next state SHALL be IDLE.
REQ-020 Fill accept SHALL drive, in the same cycle, sram_csb0=0, sram_web0=0, sram_addr0=fill index and sram_din0=fill tag.
REQ-021 On fill accept, valid[fidx] SHALL be set to 1 and dirty[fidx] SHALL be set to fill_dirty; next state is FILL.
REQ-022 A fill accepted in LOOKUP SHALL still emit that cycle's response.
REQ-023 FILL SHALL last exactly 1 cycle (SRAM write commit), then go to IDLE, so a lookup never reads a tag in flight.
REQ-024 Simultaneous fill_valid and req_valid SHALL give the fill priority; the request waits (req_ready=0).
REQ-025 A dirty-set from a write hit and a fill to the same set in the same cycle SHALL resolve with the fill winning.
REQ-026 When no access is driven: sram_csb0=1, sram_web0=1, and sram_addr0/sram_din0 hold their previous values.
REQ-027 When resp_valid=0, the resp_hit, resp_dirty, resp_victim_tag and resp_set outputs SHALL all be 0.
REQ-028 The response path SHALL have no back-pressure; the consumer must take resp in the cycle it is valid.

Reset
REQ-029 While rst=1: state goes to IDLE, all valid and dirty bits are cleared to 0, req_ready=0, fill_ready=0, resp_valid=0, sram_csb0=1 and sram_web0=1.
REQ-030 If rst is asserted during LOOKUP, the response for the in-flight lookup SHALL be dropped.
REQ-031 If rst is asserted in the cycle a fill is accepted, the valid/dirty update for that fill SHALL be dropped; the SRAM write may commit harmlessly.

Verification
REQ-032 Reset, then lookup 0x0000_1040 -> next cycle resp_valid=1, resp_hit=0, resp_dirty=0, resp_set=2.
REQ-033 Fill 0x0000_1040 with fill_dirty=0, then read lookup 0x0000_1040 -> resp_hit=1, resp_dirty=0.
REQ-034 Write lookup 0x0000_1040 (hit), then lookup 0x0000_3040 -> resp_hit=0, resp_dirty=1, resp_victim_tag=0x000008, resp_set=2.
REQ-035 fill_valid and req_valid asserted together -> fill accepted, req_ready=0; request accepted in the cycle after FILL, response one cycle later.
REQ-036 Requests on sets 0..15 on consecutive cycles after filling all sets -> 16 consecutive resp_valid pulses, all resp_hit=1.
REQ-037 rst pulsed during LOOKUP after fills -> no resp_valid on the following cycle; a subsequent lookup of any filled address misses.
